fetch_sequencer: RTL
====================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter BOOT_DELAY, default 4: cycles Halt is held after reset release; legal range 1..255.
REQ-002 SHALL have parameter STALL_TIMEOUT, default 255: consecutive Mem_Stall cycles that raise Timeout_Err; legal range 1..255.
REQ-003 SHALL have port Clk_Core, input, 1 bit: single core clock; all state changes on its rising edge.
REQ-004 SHALL have port Rst_Core_N, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port Branch_Taken, input, 1 bit: resolved conditional branch is taken this cycle.
REQ-006 SHALL have port Jump, input, 1 bit: JAL/JALR executing this cycle.
REQ-007 SHALL have port Target_Addr, input, 32 bits: branch/jump target computed by the datapath.
REQ-008 SHALL have port Mem_Stall, input, 1 bit: instruction or data memory not ready; current instruction must not retire.
REQ-009 SHALL have port Ebreak, input, 1 bit: EBREAK decoded this cycle.
REQ-010 SHALL have port Dbg_Halt_Req, input, 1 bit: level debug halt request.
REQ-011 SHALL have port Dbg_Resume, input, 1 bit: single-cycle pulse; leave HALTED and clear error flags.
REQ-012 SHALL have port Dbg_Step, input, 1 bit: single-cycle pulse; retire exactly one instruction from HALTED.
REQ-013 SHALL have port PC_Sel, output, 1 bit: program counter loads Program_Count_Imm instead of PC+4.
REQ-014 SHALL have port Halt, output, 1 bit: program counter holds its value.
REQ-015 SHALL have port Program_Count_Imm, output, 32 bits: redirect target to program counter.
REQ-016 SHALL have port Core_Halted, output, 1 bit: 1 while in HALTED.
REQ-017 SHALL have port Misalign_Err, output, 1 bit: sticky misaligned-target flag.
REQ-018 SHALL have port Timeout_Err, output, 1 bit: sticky stall-timeout flag.

Function
REQ-019 SHALL implement a registered FSM with states BOOT, RUN, HALTED, STEP; Halt, PC_Sel and Core_Halted decode combinationally from state and inputs.
REQ-020 SHALL in BOOT drive Halt=1, PC_Sel=0, and increment an 8-bit boot counter from 0 each cycle; it enters RUN on the edge where the counter equals BOOT_DELAY-1.
REQ-021 SHALL define Redirect = Branch_Taken | Jump, and Program_Count_Imm = {Target_Addr[31:1], 1'b0} at all times, including JALR bit-0 clearing.
REQ-022 SHALL in RUN and STEP drive Halt=1 whenever Mem_Stall=1, with PC_Sel=0 while Mem_Stall=1.
REQ-023 SHALL in RUN with Mem_Stall=0 evaluate events in priority order Dbg_Halt_Req > misaligned redirect > Ebreak > Redirect.
REQ-024 SHALL on Dbg_Halt_Req drive Halt=1 and PC_Sel=0 that cycle, then enter HALTED.
REQ-025 SHALL treat Redirect with Target_Addr[1]=1 as misaligned: drive Halt=1 and PC_Sel=0, set Misalign_Err, and enter HALTED.
REQ-026 SHALL on Ebreak drive Halt=1, keeping the PC at the EBREAK address, and enter HALTED.
REQ-027 SHALL on Redirect alone drive PC_Sel=1 and Halt=0; otherwise drive PC_Sel=0 and Halt=0 (sequential PC+4).
REQ-028 SHALL ignore Dbg_Halt_Req while Mem_Stall=1 and honor it on the first cycle Mem_Stall=0.
REQ-029 SHALL in HALTED drive Halt=1 and PC_Sel=0; Dbg_Resume enters RUN, or Dbg_Step enters STEP; Dbg_Resume wins if both are asserted.
REQ-030 SHALL in STEP apply the RUN rules of REQ-022..REQ-027 for one instruction, except that Dbg_Halt_Req is ignored, then return to HALTED on the first cycle Mem_Stall=0.
REQ-031 SHALL count consecutive Mem_Stall=1 cycles in RUN/STEP with an 8-bit saturating counter, clearing it on any cycle Mem_Stall=0.
REQ-032 SHALL set Timeout_Err and enter HALTED when the stall count reaches STALL_TIMEOUT.
REQ-033 SHALL clear Misalign_Err, Timeout_Err and the stall counter on Dbg_Resume; Dbg_Step clears only the stall counter.
REQ-034 SHALL ignore Branch_Taken, Jump, Ebreak, Dbg_Resume and Dbg_Step in BOOT.

Reset
REQ-035 SHALL on Rst_Core_N=0, immediately and regardless of clock, force state BOOT, boot counter 0, stall counter 0, and Misalign_Err=Timeout_Err=0.
REQ-036 SHALL as a result of reset drive Halt=1, PC_Sel=0 and Core_Halted=0.
REQ-037 SHALL restart the full BOOT_DELAY sequence when reset is asserted mid-operation in any state.

Verification
REQ-038 SHALL cover boot: release reset with BOOT_DELAY=4 -> Halt=1 for exactly 4 cycles, then Halt=0 and PC advances 0,4,8.
REQ-039 SHALL cover jump redirect: Jump=1 with Target_Addr=0x0000_0101 -> PC_Sel=1, Program_Count_Imm=0x0000_0100, next PC=0x100, Misalign_Err=0.
REQ-040 SHALL cover misalignment: Branch_Taken=1 with Target_Addr=0x0000_0202 -> PC_Sel=0, Halt=1, Misalign_Err=1, Core_Halted=1 next cycle; Dbg_Resume -> Misalign_Err=0, RUN.
REQ-041 SHALL cover EBREAK: Ebreak at PC=0x40 -> PC holds 0x40, Core_Halted=1; Dbg_Step -> PC=0x44, back to HALTED.
REQ-042 SHALL cover stall timeout: STALL_TIMEOUT=8 with Mem_Stall held -> Timeout_Err=1 after the 8th stall cycle, Core_Halted=1; 7 stall cycles then release -> no error.
REQ-043 SHALL cover halt request during stall: Dbg_Halt_Req=1 with Mem_Stall=1 for 3 cycles -> stays in RUN; Mem_Stall=0 -> Halt=1, HALTED next cycle; mid-HALTED reset -> BOOT, Core_Halted=0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: sequences the program counter through boot, normal run,
// debug halt and single-step, raising sticky flags for misaligned targets and stall timeouts.
`timescale 1ns/1ps

module fetch_sequencer #(
  parameter int unsigned BOOT_DELAY    = 4,
  parameter int unsigned STALL_TIMEOUT = 255
) (
  input  logic        Clk_Core,
  input  logic        Rst_Core_N,
  input  logic        Branch_Taken,
  input  logic        Jump,
  input  logic [31:0] Target_Addr,
  input  logic        Mem_Stall,
  input  logic        Ebreak,
  input  logic        Dbg_Halt_Req,
  input  logic        Dbg_Resume,
  input  logic        Dbg_Step,
  output logic        PC_Sel,
  output logic        Halt,
  output logic [31:0] Program_Count_Imm,
  output logic        Core_Halted,
  output logic        Misalign_Err,
  output logic        Timeout_Err
);

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2,
    ST_STEP   = 2'd3
  } state_e;

  localparam logic [7:0] BOOT_LAST   = 8'(BOOT_DELAY - 1);
  localparam logic [7:0] STALL_LIMIT = 8'(STALL_TIMEOUT);

  state_e     state_q, state_d;
  logic [7:0] boot_cnt_q, boot_cnt_d;
  logic [7:0] stall_cnt_q, stall_cnt_d;
  logic       misalign_q, misalign_d;
  logic       timeout_q, timeout_d;
  logic       halt, pc_sel;

  logic       redirect;
  logic       misaligned;
  logic [7:0] stall_sat;

  assign redirect   = Branch_Taken | Jump;
  assign misaligned = redirect & Target_Addr[1];
  assign stall_sat  = (stall_cnt_q == 8'hFF) ? 8'hFF : stall_cnt_q + 8'd1;

  // Bit 0 is always cleared so JALR targets land on a halfword boundary.
  assign Program_Count_Imm = Target_Addr & 32'hFFFF_FFFE;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    boot_cnt_d  = boot_cnt_q;
    stall_cnt_d = stall_cnt_q;
    misalign_d  = misalign_q;
    timeout_d   = timeout_q;
    halt        = 1'b1;
    pc_sel      = 1'b0;

    case (state_q)
      ST_BOOT: begin
        if (boot_cnt_q == BOOT_LAST) state_d = ST_RUN;
        else                         boot_cnt_d = boot_cnt_q + 8'd1;
      end

      ST_HALTED: begin
        if (Dbg_Resume) begin
          state_d     = ST_RUN;
          misalign_d  = 1'b0;
          timeout_d   = 1'b0;
          stall_cnt_d = 8'd0;
        end else if (Dbg_Step) begin
          state_d     = ST_STEP;
          stall_cnt_d = 8'd0;
        end
      end

      ST_RUN, ST_STEP: begin
        if (Mem_Stall) begin
          stall_cnt_d = stall_sat;
          if (stall_sat >= STALL_LIMIT) begin
            timeout_d = 1'b1;
            state_d   = ST_HALTED;
          end
        end else begin
          stall_cnt_d = 8'd0;
          // A step retires one instruction and always lands back in HALTED.
          if (state_q == ST_STEP) state_d = ST_HALTED;
          if (Dbg_Halt_Req && (state_q == ST_RUN)) begin
            state_d = ST_HALTED;
          end else if (misaligned) begin
            misalign_d = 1'b1;
            state_d    = ST_HALTED;
          end else if (Ebreak) begin
            state_d = ST_HALTED;
          end else begin
            halt   = 1'b0;
            pc_sel = redirect;
          end
        end
      end

      default: state_d = ST_BOOT;
    endcase
  end

  // NOTE: the asynchronous reset clears every state register; sequential state uses non-blocking assignments only.
  always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
    if (!Rst_Core_N) begin
      state_q     <= ST_BOOT;
      boot_cnt_q  <= 8'd0;
      stall_cnt_q <= 8'd0;
      misalign_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      misalign_q  <= misalign_d;
      timeout_q   <= timeout_d;
    end
  end

  assign Halt         = halt;
  assign PC_Sel       = pc_sel;
  assign Core_Halted  = (state_q == ST_HALTED);
  assign Misalign_Err = misalign_q;
  assign Timeout_Err  = timeout_q;

endmodule
